// File: rtl/lcb_responder.sv
`default_nettype none
// ============================================================================
// Module   : lcb_responder
// Brief    : RS485 poll-link slave. Receives a 4-byte 8N1 request, then returns
//            N register-file bytes plus an XOR checksum over the same line.
// Revision : 1.0 - initial release
// ============================================================================
module lcb_responder #(
  parameter logic [7:0] MY_ADDR    = 8'h01,
  parameter int         BIT_TICKS  = 16,
  parameter int         MAX_RSP    = 32,
  parameter int         TURN_BITS  = 2,
  parameter int         GUARD_BITS = 1,
  parameter int         GAP_BITS   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       dirTX,
  output logic       dirRX,
  output logic [7:0] rdAddr,
  output logic       rdEn,
  input  logic [7:0] rdData,
  output logic       rqValid,
  output logic       errFrame,
  output logic       busy
);

  localparam int TURN_CYC  = TURN_BITS * BIT_TICKS;
  localparam int GUARD_CYC = GUARD_BITS * BIT_TICKS;
  localparam int GAP_CYC   = GAP_BITS * BIT_TICKS;
  localparam int TW        = $clog2(BIT_TICKS);
  localparam int SW        = $clog2(TURN_CYC + GUARD_CYC + 1);
  localparam int GW        = $clog2(GAP_CYC + 1);

  localparam logic [TW-1:0] c_BIT_LAST   = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] c_HALF_LAST  = TW'(BIT_TICKS / 2 - 1);
  localparam logic [SW-1:0] c_TURN_LAST  = SW'(TURN_CYC - 1);
  localparam logic [SW-1:0] c_GUARD_LAST = SW'(GUARD_CYC - 1);
  localparam logic [GW-1:0] c_GAP_LIM    = GW'(GAP_CYC);
  localparam logic [7:0]    c_MAX_N      = 8'(MAX_RSP);

  typedef enum logic [2:0] {S_IDLE, S_TURN, S_LOAD, S_LATCH, S_SEND, S_GUARD} state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rxState_t;

  state_t        r_state;
  rxState_t      r_rxState;
  logic          r_rxMeta, r_rxSync, r_rxPrev;
  logic [TW-1:0] r_rxTick;
  logic [2:0]    r_rxBitCnt;
  logic [7:0]    r_rxShift;
  logic          r_rxValid, r_rxErr;
  logic [1:0]    r_byteCnt;
  logic [7:0]    r_b0, r_b1, r_b2;
  logic [GW-1:0] r_gapCnt;
  logic [SW-1:0] r_cnt;
  logic [7:0]    r_start, r_n, r_idx, r_xor;
  logic [8:0]    r_txFrame;
  logic [TW-1:0] r_txTick;
  logic [3:0]    r_txBitCnt;
  logic          r_sendChk;
  logic          r_dir;

  logic w_stopSample, w_csumOk, w_countOk;

  assign w_stopSample = (r_state == S_IDLE) && (r_rxState == RX_STOP) && (r_rxTick == c_BIT_LAST);
  assign w_csumOk     = (r_rxShift == (r_b0 ^ r_b1 ^ r_b2));
  assign w_countOk    = (r_b2 != 8'd0) && (r_b2 <= c_MAX_N);

  assign dirTX = r_dir;
  assign dirRX = r_dir;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rxMeta   <= 1'b1;
      r_rxSync   <= 1'b1;
      r_rxPrev   <= 1'b1;
      r_rxState  <= RX_HUNT;
      r_rxTick   <= '0;
      r_rxBitCnt <= 3'd0;
      r_rxShift  <= 8'd0;
      r_rxValid  <= 1'b0;
      r_rxErr    <= 1'b0;
      r_byteCnt  <= 2'd0;
      r_b0       <= 8'd0;
      r_b1       <= 8'd0;
      r_b2       <= 8'd0;
      r_gapCnt   <= '0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_start    <= 8'd0;
      r_n        <= 8'd0;
      r_idx      <= 8'd0;
      r_xor      <= 8'd0;
      r_txFrame  <= 9'h1FF;
      r_txTick   <= '0;
      r_txBitCnt <= 4'd0;
      r_sendChk  <= 1'b0;
      r_dir      <= 1'b0;
      tx         <= 1'b1;
      rdAddr     <= 8'd0;
      rdEn       <= 1'b0;
      rqValid    <= 1'b0;
      errFrame   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_rxMeta  <= rx;
      r_rxSync  <= r_rxMeta;
      r_rxPrev  <= r_rxSync;
      r_rxValid <= 1'b0;
      r_rxErr   <= 1'b0;
      rqValid   <= 1'b0;
      errFrame  <= 1'b0;
      rdEn      <= 1'b0;

      // The line is ours while responding, so the receiver only runs in IDLE.
      if (r_state != S_IDLE) begin
        r_rxState <= RX_HUNT;
      end else begin
        case (r_rxState)
          RX_HUNT: begin
            if (r_rxPrev && !r_rxSync) begin
              r_rxState <= RX_START;
              r_rxTick  <= '0;
            end
          end
          RX_START: begin
            if (r_rxTick == c_HALF_LAST) begin
              r_rxTick   <= '0;
              r_rxBitCnt <= 3'd0;
              r_rxState  <= r_rxSync ? RX_HUNT : RX_DATA;
            end else begin
              r_rxTick <= r_rxTick + TW'(1);
            end
          end
          RX_DATA: begin
            if (r_rxTick == c_BIT_LAST) begin
              r_rxTick   <= '0;
              r_rxShift  <= {r_rxSync, r_rxShift[7:1]};
              r_rxBitCnt <= r_rxBitCnt + 3'd1;
              if (r_rxBitCnt == 3'd7) r_rxState <= RX_STOP;
            end else begin
              r_rxTick <= r_rxTick + TW'(1);
            end
          end
          RX_STOP: begin
            if (r_rxTick == c_BIT_LAST) begin
              r_rxTick  <= '0;
              r_rxState <= RX_HUNT;
              r_rxValid <= r_rxSync;
              r_rxErr   <= !r_rxSync;
            end else begin
              r_rxTick <= r_rxTick + TW'(1);
            end
          end
          default: r_rxState <= RX_HUNT;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (r_rxErr) begin
            errFrame  <= 1'b1;
            r_byteCnt <= 2'd0;
          end else if (r_rxValid) begin
            case (r_byteCnt)
              2'd0: r_b0 <= r_rxShift;
              2'd1: r_b1 <= r_rxShift;
              2'd2: r_b2 <= r_rxShift;
              default: begin
                // Frames for other addresses are dropped without complaint.
                if (r_b0 == MY_ADDR) begin
                  if (w_csumOk && w_countOk) begin
                    rqValid   <= 1'b1;
                    busy      <= 1'b1;
                    r_state   <= S_TURN;
                    r_cnt     <= '0;
                    r_idx     <= 8'd0;
                    r_xor     <= 8'd0;
                    r_sendChk <= 1'b0;
                    r_start   <= r_b1;
                    r_n       <= r_b2;
                  end else begin
                    errFrame <= 1'b1;
                  end
                end
              end
            endcase
            r_byteCnt <= r_byteCnt + 2'd1;
          end else if ((r_byteCnt != 2'd0) && (r_gapCnt == c_GAP_LIM)) begin
            errFrame  <= 1'b1;
            r_byteCnt <= 2'd0;
          end

          if (w_stopSample || (r_byteCnt == 2'd0)) begin
            r_gapCnt <= '0;
          end else if (r_gapCnt != c_GAP_LIM) begin
            r_gapCnt <= r_gapCnt + GW'(1);
          end
        end

        S_TURN: begin
          if (r_cnt == c_TURN_LAST) begin
            r_state <= S_LOAD;
            rdEn    <= 1'b1;
            rdAddr  <= r_start + r_idx;
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end

        S_LOAD: begin
          r_dir   <= 1'b1;
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_txFrame  <= {1'b1, rdData};
          r_xor      <= r_xor ^ rdData;
          tx         <= 1'b0;
          r_txTick   <= '0;
          r_txBitCnt <= 4'd0;
          r_state    <= S_SEND;
        end

        S_SEND: begin
          if (r_txTick != c_BIT_LAST) begin
            r_txTick <= r_txTick + TW'(1);
          end else begin
            r_txTick <= '0;
            if (r_txBitCnt != 4'd9) begin
              tx         <= r_txFrame[0];
              r_txFrame  <= {1'b1, r_txFrame[8:1]};
              r_txBitCnt <= r_txBitCnt + 4'd1;
            end else if (r_sendChk) begin
              r_state <= S_GUARD;
              r_cnt   <= '0;
            end else if (r_idx != (r_n - 8'd1)) begin
              r_idx   <= r_idx + 8'd1;
              rdEn    <= 1'b1;
              rdAddr  <= r_start + r_idx + 8'd1;
              r_state <= S_LOAD;
            end else begin
              // Checksum follows the last data byte back-to-back.
              r_sendChk  <= 1'b1;
              r_txFrame  <= {1'b1, r_xor};
              tx         <= 1'b0;
              r_txBitCnt <= 4'd0;
            end
          end
        end

        S_GUARD: begin
          if (r_cnt == c_GUARD_LAST) begin
            r_dir     <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
            r_byteCnt <= 2'd0;
            r_gapCnt  <= '0;
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcb_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcb_responder
// Brief    : Directed bench for lcb_responder with a register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcb_responder;
  localparam int BT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx, dirTX, dirRX, rdEn, rqValid, errFrame, busy;
  logic [7:0] rdAddr;
  logic [7:0] rdData = 8'd0;
  logic [7:0] mem [256];

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, rqCnt = 0, errCnt = 0, bothCnt = 0, dirCnt = 0, dirMis = 0;
  int txLowCnt = 0, dirRiseCyc = 0, rdIdx = 0, firstStart = 0;
  logic [7:0] rdLog [64];
  logic dirPrev = 1'b0;

  always #5 clk = ~clk;

  lcb_responder dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .dirTX(dirTX), .dirRX(dirRX),
    .rdAddr(rdAddr), .rdEn(rdEn), .rdData(rdData),
    .rqValid(rqValid), .errFrame(errFrame), .busy(busy)
  );

  // One-cycle-latency register file
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdEn) rdData <= mem[rdAddr];
  end

  always @(negedge clk) begin
    if (rqValid) rqCnt <= rqCnt + 1;
    if (errFrame) errCnt <= errCnt + 1;
    if (rqValid && errFrame) bothCnt <= bothCnt + 1;
    if (dirTX === 1'b1) dirCnt <= dirCnt + 1;
    if (dirTX !== dirRX) dirMis <= dirMis + 1;
    if (tx === 1'b0) txLowCnt <= txLowCnt + 1;
    if (dirTX === 1'b1 && !dirPrev) dirRiseCyc <= cyc;
    dirPrev <= (dirTX === 1'b1);
    if (rdEn === 1'b1 && rdIdx < 64) begin
      rdLog[rdIdx] <= rdAddr;
      rdIdx        <= rdIdx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    @(negedge clk);
    rx = 1'b0;
    ticks(BT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(BT);
    end
    rx = stopBit;
    ticks(BT);
    rx = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2, b3);
    sendByte(b0, 1'b1);
    sendByte(b1, 1'b1);
    sendByte(b2, 1'b1);
    sendByte(b3, 1'b1);
  endtask

  task automatic recvByte(output logic [7:0] b, output logic ok, output int startCyc);
    int t = 0;
    ok = 1'b1;
    b = 8'd0;
    startCyc = 0;
    while (tx !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    startCyc = cyc;
    ticks(BT / 2);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ticks(BT);
      b[i] = tx;
    end
    ticks(BT);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic expectResp(input string tag, input int nb, input logic [7:0] e0, e1, e2, e3);
    logic [7:0] exp [4];
    logic [7:0] got;
    logic       ok;
    int         sc;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < nb; i++) begin
      recvByte(got, ok, sc);
      if (i == 0) firstStart = sc;
      chk($sformatf("%s char%0d framing", tag, i), {31'd0, ok}, 32'd1);
      chk($sformatf("%s char%0d value", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
  endtask

  task automatic waitIdle(input string tag);
    int t = 0;
    while ((busy !== 1'b0 || dirTX !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " busy low"}, {31'd0, busy}, 32'd0);
    chk({tag, " dirTX low"}, {31'd0, dirTX}, 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, e0, d0, a0, t0, w;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h04] = 8'h11; mem[8'h05] = 8'h22; mem[8'h06] = 8'h33;
    mem[8'h00] = 8'hA5; mem[8'hFE] = 8'h3C; mem[8'hFF] = 8'h5A;

    rst = 1'b0;
    rx  = 1'b1;
    ticks(4);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset dirTX", {31'd0, dirTX}, 32'd0);
    chk("reset dirRX", {31'd0, dirRX}, 32'd0);
    chk("reset rdEn", {31'd0, rdEn}, 32'd0);
    chk("reset rdAddr", {24'd0, rdAddr}, 32'd0);
    chk("reset rqValid", {31'd0, rqValid}, 32'd0);
    chk("reset errFrame", {31'd0, errFrame}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    ticks(20);

    // Basic response; a frame sent while the line is turned around is ignored
    r0 = rqCnt; d0 = dirCnt; a0 = rdIdx;
    sendFrame(8'h01, 8'h04, 8'h03, 8'h06);
    ticks(2);
    chk("t1 rqValid", rqCnt - r0, 1);
    chk("t1 busy high", {31'd0, busy}, 32'd1);
    fork
      expectResp("t1", 4, 8'h11, 8'h22, 8'h33, 8'h00);
      begin
        for (int t = 0; t < 200 && dirTX !== 1'b1; t++) @(negedge clk);
        sendFrame(8'h01, 8'h00, 8'h01, 8'h00);
      end
    join
    waitIdle("t1");
    chk("t1 dir to start", firstStart - dirRiseCyc, 1);
    chk("t1 dirTX cycles", dirCnt - d0, 1 + 10 * BT * 4 + 2 * 2 + BT);
    chk("t1 rq while busy ignored", rqCnt - r0, 1);
    chk("t1 rdEn count", rdIdx - a0, 3);
    chk("t1 rdAddr0", {24'd0, rdLog[a0]}, 32'h04);
    chk("t1 rdAddr2", {24'd0, rdLog[a0 + 2]}, 32'h06);

    // Wrong address is dropped silently
    r0 = rqCnt; e0 = errCnt; t0 = txLowCnt; d0 = dirCnt;
    sendFrame(8'h02, 8'h00, 8'h01, 8'h03);
    ticks(300);
    chk("t2 no rq", rqCnt - r0, 0);
    chk("t2 no err", errCnt - e0, 0);
    chk("t2 tx idle", txLowCnt - t0, 0);
    chk("t2 dir idle", dirCnt - d0, 0);
    sendFrame(8'h01, 8'h00, 8'h01, 8'h00);
    expectResp("t2", 2, 8'hA5, 8'hA5, 8'h00, 8'h00);
    waitIdle("t2");
    chk("t2 rq after", rqCnt - r0, 1);

    // Bad checksum, N=0, N>MAX_RSP
    r0 = rqCnt; e0 = errCnt; t0 = txLowCnt;
    sendFrame(8'h01, 8'h00, 8'h02, 8'h07);
    ticks(100);
    chk("t3 bad csum err", errCnt - e0, 1);
    sendFrame(8'h01, 8'h00, 8'h00, 8'h01);
    ticks(100);
    chk("t3 N=0 err", errCnt - e0, 2);
    sendFrame(8'h01, 8'h00, 8'h21, 8'h20);
    ticks(100);
    chk("t3 N=33 err", errCnt - e0, 3);
    chk("t3 no rq", rqCnt - r0, 0);
    chk("t3 tx idle", txLowCnt - t0, 0);

    // Start-address wraparound
    a0 = rdIdx;
    sendFrame(8'h01, 8'hFE, 8'h03, 8'hFC);
    expectResp("t4", 4, 8'h3C, 8'h5A, 8'hA5, 8'hC3);
    waitIdle("t4");
    chk("t4 rdAddr0", {24'd0, rdLog[a0]}, 32'hFE);
    chk("t4 rdAddr1", {24'd0, rdLog[a0 + 1]}, 32'hFF);
    chk("t4 rdAddr2", {24'd0, rdLog[a0 + 2]}, 32'h00);

    // Inter-byte gap timeout, then a clean frame
    r0 = rqCnt; e0 = errCnt;
    sendByte(8'h01, 1'b1);
    sendByte(8'h04, 1'b1);
    ticks(21 * BT);
    chk("t5 gap err", errCnt - e0, 1);
    chk("t5 gap no rq", rqCnt - r0, 0);
    sendFrame(8'h01, 8'h04, 8'h03, 8'h06);
    expectResp("t5", 4, 8'h11, 8'h22, 8'h33, 8'h00);
    waitIdle("t5");
    chk("t5 rq after gap", rqCnt - r0, 1);

    // Stop bit low
    e0 = errCnt;
    sendByte(8'h01, 1'b0);
    ticks(400);
    chk("t5 stop err", errCnt - e0, 1);

    // Short glitch must not produce a byte
    r0 = rqCnt; e0 = errCnt;
    @(negedge clk);
    rx = 1'b0;
    ticks(3);
    rx = 1'b1;
    ticks(400);
    chk("t5 glitch no err", errCnt - e0, 0);
    sendFrame(8'h01, 8'h00, 8'h01, 8'h00);
    expectResp("t5g", 2, 8'hA5, 8'hA5, 8'h00, 8'h00);
    waitIdle("t5g");
    chk("t5 glitch rq", rqCnt - r0, 1);

    // Reset during the second response character
    sendFrame(8'h01, 8'h04, 8'h03, 8'h06);
    expectResp("t6", 1, 8'h11, 8'h00, 8'h00, 8'h00);
    w = 0;
    while (tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("t6 second char started", {31'd0, tx}, 32'd0);
    ticks(40);
    rst = 1'b0;
    ticks(1);
    chk("t6 reset tx", {31'd0, tx}, 32'd1);
    chk("t6 reset dirTX", {31'd0, dirTX}, 32'd0);
    chk("t6 reset dirRX", {31'd0, dirRX}, 32'd0);
    chk("t6 reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    ticks(20);
    r0 = rqCnt;
    sendFrame(8'h01, 8'hFE, 8'h03, 8'hFC);
    expectResp("t6r", 4, 8'h3C, 8'h5A, 8'hA5, 8'hC3);
    waitIdle("t6r");
    chk("t6 rq after reset", rqCnt - r0, 1);

    chk("rq/err overlap", bothCnt, 0);
    chk("dirRX follows dirTX", dirMis, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcb_responder.md
Name: lcb_responder

Overview:
- RS485 slave-side responder for the local commutation block (LCB) end of the poll link.
- The central unit sends a fixed 4-byte request over the half-duplex line. This block receives and validates it, then turns the line around and returns N data bytes plus an XOR checksum.
- Data bytes are read from an external register file through a 1-cycle-latency read port.
- The block contains its own 8N1 receiver, transmitter, direction control and sequencing FSM.

Parameters:
- MY_ADDR, 8'h01, device address this responder answers to.
- BIT_TICKS, 16, clk cycles per UART bit (80 MHz / 16 = 5 Mbaud); minimum 4.
- MAX_RSP, 32, maximum response data bytes; requests with N > MAX_RSP are rejected.
- TURN_BITS, 2, idle bit-times between the request stop bit and driving the line.
- GUARD_BITS, 1, bit-times dirTX stays high after the last stop bit.
- GAP_BITS, 20, maximum idle bit-times between request bytes before the frame is discarded.

Ports:
- clk  in  1  system clock, 80 MHz.
- rst  in  1  synchronous active-low reset.
- rx  in  1  RS485 receive line, asynchronous, idle high.
- tx  out  1  serial transmit data, idle high.
- dirTX  out  1  driver enable; 1 while transmitting.
- dirRX  out  1  receiver disable (RE#); equal to dirTX.
- rdAddr  out  8  register-file read address.
- rdEn  out  1  read strobe; rdData is valid on the cycle after rdEn.
- rdData  in  8  register-file read data.
- rqValid  out  1  one-cycle pulse when a valid request addressed to MY_ADDR is accepted.
- errFrame  out  1  one-cycle pulse on a stop-bit error, checksum mismatch, N=0, N>MAX_RSP, or gap timeout.
- busy  out  1  high from request acceptance until GUARD completes.

Behaviour:
- Reset (rst=0 at a clk edge): tx=1, dirTX=0, dirRX=0, rdEn=0, rdAddr=0, rqValid=0, errFrame=0, busy=0, FSM=IDLE, byte counter=0. Reset mid-transmission aborts immediately; tx returns to 1 on the same edge.
- rx input: passes through a 2-flop synchronizer. The receiver is active only in IDLE; rx is ignored in all other states.
- Receiver:
  - A falling edge starts a bit timer. At BIT_TICKS/2 the start bit is re-checked; if rx=1 the edge was a glitch, return to hunt.
  - Data bits are sampled every BIT_TICKS, LSB first.
  - The stop bit is sampled at its midpoint; stop=0 gives errFrame and the frame is discarded.
- Request frame: b0 = address, b1 = start register S, b2 = count N, b3 = b0^b1^b2.
  - If b0 != MY_ADDR the frame is silently dropped: no errFrame, counter cleared after b3.
  - Bad checksum, N=0 or N>MAX_RSP gives errFrame and no response.
  - Gap timer: counts from each stop-bit sample. If it exceeds GAP_BITS*BIT_TICKS with the byte counter nonzero, errFrame and counter=0.
- FSM:
  - IDLE: on a valid frame, pulse rqValid, set busy=1, go to TURN.
  - TURN: wait TURN_BITS*BIT_TICKS cycles, then go to LOAD.
  - LOAD: rdAddr=S+i (8-bit wrap, 8'hFF+1 -> 8'h00), rdEn=1 for exactly one cycle. Next cycle latch rdData into the shifter and into the XOR accumulator, go to SEND.
  - SEND: set dirTX=dirRX=1 one cycle before the first start bit. Shift out start(0), 8 data bits LSB first, stop(1), each BIT_TICKS cycles.
    - After a data byte with i<N-1: i++ and return to LOAD. tx holds 1 during the LOAD cycles, so the inter-byte gap is 2 cycles.
    - After data byte N-1: send the checksum byte (XOR of all N data bytes), then go to GUARD.
  - GUARD: tx=1 for GUARD_BITS*BIT_TICKS cycles, then dirTX=dirRX=0, busy=0, clear the receiver, go to IDLE.
- Latency: first start bit begins (TURN_BITS*BIT_TICKS)+3 cycles after the stop-bit sample of b3.
- Total response length: (N+1) characters.
- rqValid and errFrame are never asserted in the same cycle.

Test Plan:
- Request 01 04 03 06 with registers [4]=11,[5]=22,[6]=33: rqValid pulse; after turnaround tx sends 11 22 33 then checksum 00; dirTX high across the burst plus 16 cycles; busy then falls.
- Request 02 00 01 03 (wrong address): no rqValid, no errFrame, tx/dirTX stay idle; next valid 01 00 01 00 is answered normally.
- Request 01 00 02 07 (bad checksum): errFrame pulse, no response; with N=0 (01 00 00 01) and N=33 (01 00 21 20) errFrame also pulses.
- Wraparound: S=FE, N=3 (01 FE 03 FC): rdAddr sequence FE, FF, 00; checksum = XOR of the three bytes read.
- Send 2 bytes, idle 21 bit-times, then send 4 bytes: errFrame on timeout; the subsequent 4-byte valid frame is accepted. A stop bit forced to 0 also gives errFrame; a 3-cycle low glitch on rx produces no byte.
- Reset: assert rst low during the 2nd response byte: next cycle tx=1, dirTX=0, busy=0; after release a new request is served correctly. Bytes on rx during the transmission are ignored.
